// File: rtl/dphy_word_align.sv
// Purpose : deskews per-lane D-PHY byte streams so each lane's first HS byte lands in the same output word.
// Latency : one byte_clk from the first cycle with every lane valid to valid_o; a word every cycle while locked.
// Backpressure: none; free-running stream, the consumer must accept a word every cycle valid_o is high.
// Optional: define DPHY_WORD_ALIGN_SKEW_ERR_EN to add the skew_err_o pulse output.
module dphy_word_align #(
  parameter int DATA_LANES = 4,
  parameter int MAX_SKEW   = 3
) (
  input  logic                    byte_clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    pkt_done_i,
  input  logic                    wait_for_sync_i,
  input  logic [DATA_LANES*8-1:0] byte_data_i,
  input  logic [DATA_LANES-1:0]   valid_i,
`ifdef DPHY_WORD_ALIGN_SKEW_ERR_EN
  output logic                    skew_err_o,
`endif
  output logic                    pkt_done_o,
  output logic [DATA_LANES*8-1:0] word_o,
  output logic                    valid_o
);

  localparam int CW = $clog2(MAX_SKEW + 2);

  typedef enum logic [1:0] {IDLE, HUNT, LOCKED, SKEW_ERR} state_t;

  state_t                  state;
  logic [7:0]              dly    [DATA_LANES][MAX_SKEW];
  logic [CW-1:0]           cnt    [DATA_LANES];
  logic [CW-1:0]           offset [DATA_LANES];
  logic                    all_vld;
  logic                    any_vld;
  logic                    skew_hit;
  logic [DATA_LANES*8-1:0] hunt_word;
  logic [DATA_LANES*8-1:0] lock_word;

  // Per-lane byte history; dly[n][k-1] is the byte k cycles old (tap k).
  always_ff @(posedge byte_clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int n = 0; n < DATA_LANES; n++)
        for (int k = 0; k < MAX_SKEW; k++)
          dly[n][k] <= '0;
    end else begin
      for (int n = 0; n < DATA_LANES; n++) begin
        dly[n][0] <= byte_data_i[n*8 +: 8];
        for (int k = 1; k < MAX_SKEW; k++)
          dly[n][k] <= dly[n][k-1];
      end
    end
  end

  // Tap selection: hunt_word uses the live counters (lock cycle), lock_word the latched offsets.
  always_comb begin
    all_vld   = &valid_i;
    any_vld   = |valid_i;
    skew_hit  = 1'b0;
    hunt_word = '0;
    lock_word = '0;
    for (int n = 0; n < DATA_LANES; n++) begin
      // A lane already MAX_SKEW cycles ahead that stays valid without the others would exceed the tap range.
      if (valid_i[n] && (cnt[n] == CW'(MAX_SKEW)))
        skew_hit = 1'b1;
      if (cnt[n] == '0)
        hunt_word[n*8 +: 8] = byte_data_i[n*8 +: 8];
      if (offset[n] == '0)
        lock_word[n*8 +: 8] = byte_data_i[n*8 +: 8];
      for (int k = 1; k <= MAX_SKEW; k++) begin
        if (cnt[n] == CW'(k))
          hunt_word[n*8 +: 8] = dly[n][k-1];
        if (offset[n] == CW'(k))
          lock_word[n*8 +: 8] = dly[n][k-1];
      end
    end
  end

  // Alignment FSM with registered word/valid/pkt_done (and optional skew error pulse).
  always_ff @(posedge byte_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      word_o     <= '0;
      valid_o    <= 1'b0;
      pkt_done_o <= 1'b0;
`ifdef DPHY_WORD_ALIGN_SKEW_ERR_EN
      skew_err_o <= 1'b0;
`endif
      for (int n = 0; n < DATA_LANES; n++) begin
        cnt[n]    <= '0;
        offset[n] <= '0;
      end
    end else begin
      pkt_done_o <= enable_i & pkt_done_i;
      word_o     <= '0;
      valid_o    <= 1'b0;
`ifdef DPHY_WORD_ALIGN_SKEW_ERR_EN
      skew_err_o <= 1'b0;
`endif
      if (!enable_i) begin
        state <= IDLE;
        for (int n = 0; n < DATA_LANES; n++)
          cnt[n] <= '0;
      end else begin
        case (state)
          IDLE: begin
            for (int n = 0; n < DATA_LANES; n++)
              cnt[n] <= '0;
            if (wait_for_sync_i)
              state <= HUNT;
          end
          HUNT: begin
            if (all_vld) begin
              // Last-arriving lane has count 0; earlier lanes read older taps.
              for (int n = 0; n < DATA_LANES; n++)
                offset[n] <= cnt[n];
              word_o  <= hunt_word;
              valid_o <= 1'b1;
              state   <= LOCKED;
            end else begin
              for (int n = 0; n < DATA_LANES; n++)
                if (valid_i[n] && (cnt[n] != CW'(MAX_SKEW + 1)))
                  cnt[n] <= cnt[n] + CW'(1);
              if (skew_hit) begin
                state <= SKEW_ERR;
`ifdef DPHY_WORD_ALIGN_SKEW_ERR_EN
                skew_err_o <= 1'b1;
`endif
              end
            end
          end
          LOCKED: begin
            // The exit cycle's word is still delivered; valid drops afterwards.
            word_o  <= lock_word;
            valid_o <= 1'b1;
            if (pkt_done_i || !any_vld)
              state <= IDLE;
          end
          SKEW_ERR: begin
            if (!any_vld)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dphy_word_align.sv
// Directed bench for dphy_word_align: skewed lock, zero/max skew, skew error, pkt_done, enable, async reset.
// Lane stimulus: each lane sends an incrementing byte from its own start cycle, 0xFF while not valid.
// Outputs are sampled 1 time unit after the rising edge.
module tb_dphy_word_align;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        pkt_done;
  logic        wait_sync;
  logic [31:0] byte_data;
  logic [3:0]  valid;
  logic        pkt_done_o;
  logic [31:0] word_o;
  logic        valid_o;
`ifdef DPHY_WORD_ALIGN_SKEW_ERR_EN
  logic        skew_err_o;
`endif

  int nvec = 0;
  int nerr = 0;
  int st [4];
  int en [4];

  dphy_word_align #(.DATA_LANES(4), .MAX_SKEW(3)) dut (
    .byte_clk_i      (clk),
    .rst_i           (rst),
    .enable_i        (enable),
    .pkt_done_i      (pkt_done),
    .wait_for_sync_i (wait_sync),
    .byte_data_i     (byte_data),
    .valid_i         (valid),
`ifdef DPHY_WORD_ALIGN_SKEW_ERR_EN
    .skew_err_o      (skew_err_o),
`endif
    .pkt_done_o      (pkt_done_o),
    .word_o          (word_o),
    .valid_o         (valid_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive cycle i of a burst described by st[]/en[].
  task automatic drive_burst(input int i);
    for (int n = 0; n < 4; n++) begin
      if (i >= st[n] && i < en[n]) begin
        valid[n] = 1'b1;
        byte_data[n*8 +: 8] = 8'(i - st[n]);
      end else begin
        valid[n] = 1'b0;
        byte_data[n*8 +: 8] = 8'hFF;
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    valid = 4'h0;
    byte_data = 32'hFFFF_FFFF;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; pkt_done = 1'b0; wait_sync = 1'b0;
    valid = 4'h0; byte_data = 32'hFFFF_FFFF;
    repeat (3) tick();
    nvec++;
    if ({pkt_done_o, valid_o, word_o} !== 34'h0) begin
      nerr++;
      $display("FAIL reset_state: got pd=%b v=%b w=%h, want all 0", pkt_done_o, valid_o, word_o);
    end
`ifdef DPHY_WORD_ALIGN_SKEW_ERR_EN
    nvec++;
    if (skew_err_o !== 1'b0) begin
      nerr++;
      $display("FAIL reset_skew_err: got %b want 0", skew_err_o);
    end
`endif
    rst = 1'b0;
    enable = 1'b1;
    tick();
  endtask

  // Lane 0 at 0, lanes 1-2 at 1, lane 3 at 2: lock at cycle 2, offsets {2,1,1,0}.
  task automatic test_skew_lock();
    logic [7:0] b;
    logic [31:0] ew;
    st = '{0, 1, 1, 2};
    en = '{10, 10, 10, 10};
    wait_sync = 1'b1;
    idle_cycles(1);
    for (int i = 0; i <= 11; i++) begin
      drive_burst(i);
      if (i >= 3) wait_sync = 1'b0;
      tick();
      b = 8'(i - 2);
      if (i < 2)        ew = 32'h0;
      else if (i < 10)  ew = {4{b}};
      else if (i == 10) ew = 32'hFF08_0808;
      else              ew = 32'h0;
      nvec++;
      if ({valid_o, word_o} !== {(i >= 2 && i <= 10), ew}) begin
        nerr++;
        $display("FAIL skew_lock[%0d]: got v=%b w=%h, want v=%b w=%h", i, valid_o, word_o, (i >= 2 && i <= 10), ew);
      end
    end
  endtask

  task automatic test_zero_skew();
    wait_sync = 1'b1;
    idle_cycles(1);
    valid = 4'hF;
    byte_data = 32'h3322_11B8;
    tick();
    nvec++;
    if ({valid_o, word_o} !== {1'b1, 32'h3322_11B8}) begin
      nerr++;
      $display("FAIL zero_skew_first: got v=%b w=%h, want v=1 w=332211b8", valid_o, word_o);
    end
    wait_sync = 1'b0;
    byte_data = 32'h7766_5544;
    tick();
    nvec++;
    if ({valid_o, word_o} !== {1'b1, 32'h7766_5544}) begin
      nerr++;
      $display("FAIL zero_skew_second: got v=%b w=%h, want v=1 w=77665544", valid_o, word_o);
    end
    idle_cycles(1);
    nvec++;
    if ({valid_o, word_o} !== {1'b1, 32'hFFFF_FFFF}) begin
      nerr++;
      $display("FAIL zero_skew_exit: got v=%b w=%h, want v=1 w=ffffffff", valid_o, word_o);
    end
    idle_cycles(1);
    nvec++;
    if ({valid_o, word_o} !== 33'h0) begin
      nerr++;
      $display("FAIL zero_skew_after: got v=%b w=%h, want v=0 w=0", valid_o, word_o);
    end
  endtask

  // Skew exactly MAX_SKEW still locks: offsets {3,2,1,0}.
  task automatic test_max_skew();
    logic [7:0] b;
    st = '{0, 1, 2, 3};
    en = '{100, 100, 100, 100};
    wait_sync = 1'b1;
    idle_cycles(1);
    for (int i = 0; i <= 6; i++) begin
      drive_burst(i);
      if (i >= 4) wait_sync = 1'b0;
      tick();
      b = 8'(i - 3);
      nvec++;
      if ({valid_o, word_o} !== ((i >= 3) ? {1'b1, {4{b}}} : 33'h0)) begin
        nerr++;
        $display("FAIL max_skew[%0d]: got v=%b w=%h, want v=%b byte=%h", i, valid_o, word_o, (i >= 3), b);
      end
    end
    idle_cycles(2);
    nvec++;
    if (valid_o !== 1'b0) begin
      nerr++;
      $display("FAIL max_skew_end: got v=%b want 0", valid_o);
    end
  endtask

  // Skew of 4 errors out; after all lanes drop, a skew-2 burst locks.
  task automatic test_skew_err();
    logic [7:0] b;
    st = '{0, 0, 0, 4};
    en = '{7, 7, 7, 7};
    wait_sync = 1'b1;
    idle_cycles(1);
    for (int i = 0; i <= 6; i++) begin
      drive_burst(i);
      tick();
      nvec++;
      if ({valid_o, word_o} !== 33'h0) begin
        nerr++;
        $display("FAIL skew_err_quiet[%0d]: got v=%b w=%h, want 0", i, valid_o, word_o);
      end
`ifdef DPHY_WORD_ALIGN_SKEW_ERR_EN
      nvec++;
      if (skew_err_o !== (i == 3)) begin
        nerr++;
        $display("FAIL skew_err_pulse[%0d]: got %b want %b", i, skew_err_o, (i == 3));
      end
`endif
    end
    idle_cycles(2);
    st = '{0, 2, 1, 0};
    en = '{100, 100, 100, 100};
    for (int i = 0; i <= 5; i++) begin
      drive_burst(i);
      if (i >= 3) wait_sync = 1'b0;
      tick();
      b = 8'(i - 2);
      nvec++;
      if ({valid_o, word_o} !== ((i >= 2) ? {1'b1, {4{b}}} : 33'h0)) begin
        nerr++;
        $display("FAIL skew_err_relock[%0d]: got v=%b w=%h, want v=%b byte=%h", i, valid_o, word_o, (i >= 2), b);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_pkt_done();
    logic [7:0] b;
    st = '{0, 0, 0, 0};
    en = '{100, 100, 100, 100};
    wait_sync = 1'b1;
    idle_cycles(1);
    for (int i = 0; i <= 6; i++) begin
      drive_burst(i);
      if (i >= 2) wait_sync = 1'b0;
      pkt_done = (i == 5);
      tick();
      b = 8'(i);
      nvec++;
      if ({pkt_done_o, valid_o, word_o} !== ((i <= 5) ? {(i == 5), 1'b1, {4{b}}} : 34'h0)) begin
        nerr++;
        $display("FAIL pkt_done[%0d]: got pd=%b v=%b w=%h, want pd=%b v=%b byte=%h",
                 i, pkt_done_o, valid_o, word_o, (i == 5), (i <= 5), b);
      end
    end
    pkt_done = 1'b0;
    idle_cycles(2);
    st = '{1, 0, 0, 0};
    wait_sync = 1'b1;
    idle_cycles(1);
    for (int i = 0; i <= 4; i++) begin
      drive_burst(i);
      if (i >= 2) wait_sync = 1'b0;
      tick();
      b = 8'(i - 1);
      nvec++;
      if ({valid_o, word_o} !== ((i >= 1) ? {1'b1, {4{b}}} : 33'h0)) begin
        nerr++;
        $display("FAIL pkt_done_relock[%0d]: got v=%b w=%h, want v=%b byte=%h", i, valid_o, word_o, (i >= 1), b);
      end
    end
    idle_cycles(2);
  endtask

  task automatic test_enable_low();
    st = '{0, 0, 0, 0};
    en = '{100, 100, 100, 100};
    enable = 1'b0;
    wait_sync = 1'b1;
    idle_cycles(1);
    for (int i = 0; i <= 5; i++) begin
      drive_burst(i);
      pkt_done = (i == 2);
      tick();
      nvec++;
      if ({pkt_done_o, valid_o, word_o} !== 34'h0) begin
        nerr++;
        $display("FAIL enable_low[%0d]: got pd=%b v=%b w=%h, want all 0", i, pkt_done_o, valid_o, word_o);
      end
    end
    pkt_done = 1'b0;
    wait_sync = 1'b0;
    idle_cycles(1);
    enable = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_reset_mid_lock();
    logic [7:0] b;
    st = '{0, 0, 0, 0};
    en = '{100, 100, 100, 100};
    wait_sync = 1'b1;
    idle_cycles(1);
    for (int i = 0; i <= 2; i++) begin
      drive_burst(i);
      if (i >= 1) wait_sync = 1'b0;
      tick();
      b = 8'(i);
      nvec++;
      if ({valid_o, word_o} !== {1'b1, {4{b}}}) begin
        nerr++;
        $display("FAIL rst_lock[%0d]: got v=%b w=%h, want v=1 byte=%h", i, valid_o, word_o, b);
      end
    end
    #3 rst = 1'b1;
    #1;
    nvec++;
    if ({valid_o, word_o} !== 33'h0) begin
      nerr++;
      $display("FAIL rst_async_clear: got v=%b w=%h, want 0", valid_o, word_o);
    end
    tick();
    rst = 1'b0;
    for (int i = 3; i <= 8; i++) begin
      drive_burst(i);
      wait_sync = (i >= 7);
      tick();
      b = 8'(i);
      nvec++;
      if ({valid_o, word_o} !== ((i == 8) ? {1'b1, {4{b}}} : 33'h0)) begin
        nerr++;
        $display("FAIL rst_idle_hold[%0d]: got v=%b w=%h, want v=%b byte=%h", i, valid_o, word_o, (i == 8), b);
      end
    end
    wait_sync = 1'b0;
    idle_cycles(2);
  endtask

  initial begin
    test_reset();
    test_skew_lock();
    test_zero_skew();
    test_max_skew();
    test_skew_err();
    test_pkt_done();
    test_enable_low();
    test_reset_mid_lock();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dphy_word_align.md
Name: dphy_word_align

Overview:
- Deskews the per-lane byte streams coming out of the D-PHY byte aligners.
- Each lane's HS burst can start up to MAX_SKEW byte clocks apart; the block delays the early lanes so the first byte of every lane appears in the same output word.
- Sits between the per-lane byte aligners and the CSI-2 lane merger / packet parser. It outputs one DATA_LANES-byte word per cycle while locked.

Parameters:
- DATA_LANES, 4, number of D-PHY data lanes (1..4).
- MAX_SKEW, 3, maximum inter-lane start skew tolerated, in byte_clk cycles.

Ports:
- byte_clk_i  in  1  byte clock; single clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- enable_i  in  1  block enable; low forces IDLE and zero outputs.
- pkt_done_i  in  1  end-of-packet strobe from downstream parser; ends the lock.
- wait_for_sync_i  in  1  arms alignment hunt for the next burst.
- byte_data_i  in  DATA_LANES x 8  per-lane byte; lane n in bits [n*8+7:n*8].
- valid_i  in  DATA_LANES  per-lane byte valid (high from the lane's first sync-aligned byte).
- pkt_done_o  out  1  pkt_done_i delayed to match data latency.
- word_o  out  DATA_LANES x 8  aligned word, lane n in byte n.
- valid_o  out  1  word_o valid.

Behaviour:
- Reset (async, rst_i high): state=IDLE, word_o=0, valid_o=0, pkt_done_o=0, all counters and offsets 0, delay lines 0.
- Per lane, an unconditional delay line of MAX_SKEW registers on byte_data_i gives taps: tap0 = current byte, tapk = byte k cycles old.
- Per lane, a skew counter cnt[n] (width clog2(MAX_SKEW+2)) counts cycles with valid_i[n]=1 during HUNT. It saturates at MAX_SKEW+1.
- States:
  - IDLE: -> HUNT when enable_i && wait_for_sync_i. Counters cleared.
  - HUNT:
    - In a cycle where all valid_i are high: latch offset[n]=cnt[n] (the last-arriving lane gets offset 0), then -> LOCKED.
    - Else, if any cnt[n] reaches MAX_SKEW+1: -> SKEW_ERR.
    - Else: counters increment for lanes whose valid_i is high.
  - LOCKED:
    - Every cycle, word_o[n] <= tap[offset[n]] of lane n (registered) and valid_o <= 1.
    - Exit to IDLE on pkt_done_i, or on all valid_i low. The registered word of that cycle is still emitted with valid_o=1. valid_o drops the following cycle.
    - wait_for_sync_i is ignored while LOCKED.
  - SKEW_ERR: outputs zero. -> IDLE once all valid_i are low.
- Latency: valid_o rises one cycle after the first cycle in which all valid_i are high. The first valid word holds each lane's first valid byte. Subsequent words follow consecutively with no gaps.
- pkt_done_o = pkt_done_i registered once (same one-cycle latency as word_o); 0 when enable_i is low.
- word_o = 0 whenever valid_o = 0.
- enable_i low has priority over everything: next state IDLE, outputs 0 next cycle.
- Zero skew (all lanes rise together): all offsets 0, latency 1.
- Skew exactly MAX_SKEW: lock succeeds. Skew of MAX_SKEW+1: SKEW_ERR, no valid_o.
- A lane dropping valid_i while LOCKED (staggered end of burst) does not change offsets; the data is passed through as-is until an exit condition.
- Reset mid-LOCKED: outputs clear immediately (async). Returns to IDLE.

Optional Feature:
- Macro DPHY_WORD_ALIGN_SKEW_ERR_EN.
- Defined: adds output port skew_err_o (1 bit). It is a registered one-cycle pulse on the HUNT->SKEW_ERR transition, reset value 0.
- Not defined: port absent. SKEW_ERR recovery behaviour is unchanged.

Test Plan:
- Per-lane counters, each starting at 0 and incrementing every cycle from that lane's valid rise. Lane 0 rises at cycle T, lanes 1–2 at T+1, lane 3 at T+2, wait_for_sync_i=1 (dropped after valid_o) -> valid_o rises at T+3 with word_o=32'h00000000, then 32'h01010101, 32'h02020202, ... every cycle with no gaps.
- All 4 lanes rise together with lane bytes 0xB8, 0x11, 0x22, 0x33 -> valid_o one cycle later, word_o=32'h332211B8.
- Lane 3 rises 4 cycles after lane 0 (MAX_SKEW=3) -> valid_o stays 0. With DPHY_WORD_ALIGN_SKEW_ERR_EN, skew_err_o pulses once. After all valid_i go low and a new burst arrives with skew 2, the block locks correctly.
- Locked stream, pkt_done_i pulsed at cycle P -> pkt_done_o high at P+1, valid_o high at P+1 and low at P+2. A new burst with wait_for_sync_i=1 relocks.
- enable_i=0 during a valid burst -> valid_o, word_o and pkt_done_o all stay 0.
- rst_i asserted mid-LOCKED between clock edges -> valid_o and word_o go 0 immediately. After release, the block stays IDLE until wait_for_sync_i.
